block_serial_subtractor: RTL
============================

Name: block_serial_subtractor

Overview:
- Multi-cycle subtractor: computes diff = a - b on WIDTH = BLOCK_LEN*NUM_BLOCKS bit operands, one BLOCK_LEN slice per clock, LSB slice first.
- Each slice is computed as a + ~b + carry. Both slice carry chains (carry-in 0 and carry-in 1) are precomputed, and the registered inter-slice carry selects between them.
- Produces the borrow and signed-overflow flags.
- Sits beside the adder blocks in the datapath, with valid/ready handshakes on both the operand side and the result side.

Parameters:
- BLOCK_LEN, 4, bits per slice (same meaning as the adder slice width).
- NUM_BLOCKS, 4, number of slices; WIDTH = BLOCK_LEN*NUM_BLOCKS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  1 when unsigned a < b.
- ovf  output  1  signed (two's complement) overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values, applied on any clk edge with rst=1 and overriding all other activity:
  - state=IDLE, diff=0, borrow_out=0, ovf=0, out_valid=0, busy=0.
  - Slice index=0, carry register=1, operand registers=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - latch a, and ~b into the operand registers;
    - carry register <= 1;
    - index <= 0;
    - go to RUN.
  - Without in_valid: stay in IDLE.
- State RUN (in_ready=0):
  - Each edge processes the slice at index. Both the c=0 and c=1 chains are evaluated from registered operands (generate = a&~b, propagate = a|~b), and the registered carry selects the slice sum and carry-out.
  - diff[index*BLOCK_LEN +: BLOCK_LEN] <= selected sum.
  - carry <= selected carry-out.
  - index <= index+1.
  - When index==NUM_BLOCKS-1:
    - go to DONE;
    - borrow_out <= ~final carry;
    - ovf <= (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]), using the final MSB sum bit.
  - The index wraps to 0 on entry to DONE.
- State DONE:
  - out_valid=1, in_ready=0; diff, borrow_out and ovf are held stable.
  - On out_ready=1: go to IDLE, out_valid deasserts after that edge.
  - in_valid is ignored in DONE and RUN; no operand is queued.
- Latency:
  - Operands accepted at edge k give out_valid=1 after edge k+NUM_BLOCKS.
  - Minimum issue period is NUM_BLOCKS+2 edges: accept, NUM_BLOCKS slices, result handshake.
- Output hold rules:
  - diff/borrow_out/ovf retain the last result in IDLE until the next accept.
  - During RUN, diff is partially updated and is valid only while out_valid=1.
- Boundary cases:
  - a==b gives diff=0, borrow_out=0.
  - A borrow ripples across all slices through the registered carry; there is no combinational path between slices.
- Reset mid-RUN or mid-DONE aborts the operation: the next cycle is IDLE with all outputs at their reset values. A new operation after reset is unaffected by the aborted one.
- busy = (state!=IDLE).

Test Plan (BLOCK_LEN=4, NUM_BLOCKS=4, WIDTH=16):
- Basic subtract: a=0x1234, b=0x0234, accepted at edge k -> out_valid after edge k+4; diff=0x1000, borrow_out=0, ovf=0.
- Full borrow ripple: a=0x0000, b=0x0001 -> diff=0xFFFF, borrow_out=1, ovf=0; a=0x0010, b=0x0001 -> diff=0x000F, borrow_out=0.
- Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, borrow_out=0, ovf=1; a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow_out=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles in DONE while in_valid pulses with new operands -> diff/flags stable, in_ready=0, new operands not taken. Raising out_ready -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst for one edge after 2 slices are processed -> out_valid=0, diff=0, state IDLE. Then a=0x00FF, b=0x00FE -> diff=0x0001, borrow_out=0.
- Streaming: in_valid=1 and out_ready=1 held with an incrementing operand sequence -> one result every 6 edges, each result correct, no operand dropped or duplicated.

Source files
------------

// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b one BLOCK_LEN slice per clock, LSB slice first.
// Each slice uses carry-select between precomputed c=0 and c=1 chains of a + ~b.
module block_serial_subtractor #(
    parameter int unsigned BLOCK_LEN  = 4,
    parameter int unsigned NUM_BLOCKS = 4,
    localparam int unsigned WIDTH     = BLOCK_LEN * NUM_BLOCKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned IdxW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned Msb  = WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    nb_q, nb_d;
    logic [WIDTH-1:0]    diff_q, diff_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                borrow_q, borrow_d;
    logic                ovf_q, ovf_d;

    logic [BLOCK_LEN-1:0] a_sl, nb_sl, gen, prop, sum0, sum1, sel_sum;
    logic [BLOCK_LEN:0]   c0, c1;
    logic                 sel_cout;
    logic                 last_slice;

    // Both carry chains are evaluated every cycle; the registered inter-slice
    // carry only drives the final select, so no combinational path spans slices.
    always_comb begin
        a_sl  = a_q[idx_q * BLOCK_LEN +: BLOCK_LEN];
        nb_sl = nb_q[idx_q * BLOCK_LEN +: BLOCK_LEN];
        gen   = a_sl & nb_sl;
        prop  = a_sl | nb_sl;
        c0    = '0;
        c1    = '0;
        sum0  = '0;
        sum1  = '0;
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int i = 0; i < int'(BLOCK_LEN); i++) begin
            c0[i+1] = gen[i] | (prop[i] & c0[i]);
            c1[i+1] = gen[i] | (prop[i] & c1[i]);
            sum0[i] = a_sl[i] ^ nb_sl[i] ^ c0[i];
            sum1[i] = a_sl[i] ^ nb_sl[i] ^ c1[i];
        end
        sel_sum  = carry_q ? sum1 : sum0;
        sel_cout = carry_q ? c1[BLOCK_LEN] : c0[BLOCK_LEN];
    end

    assign last_slice = (idx_q == IdxW'(NUM_BLOCKS - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                diff_d[idx_q * BLOCK_LEN +: BLOCK_LEN] = sel_sum;
                carry_d = sel_cout;
                if (last_slice) begin
                    idx_d    = '0;
                    state_d  = StDone;
                    borrow_d = ~sel_cout;
                    // a and b differ in sign iff a[Msb] equals the stored ~b[Msb]
                    ovf_d    = (a_q[Msb] == nb_q[Msb]) & (sel_sum[BLOCK_LEN-1] != a_q[Msb]);
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            nb_q     <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule
